// File: rtl/vga_pkg.sv
// Shared definitions for the VGA/CPU memory arbiter: owner encoding and defaults.
package vga_pkg;
    localparam int STARVE_LIMIT_DEF = 8;
    localparam int AW_DEF           = 16;
    localparam int DW               = 16;

    // Grant type recorded for the data returning in the following cycle.
    typedef enum logic [1:0] {
        OWN_IDLE   = 2'd0,
        OWN_VGA_RD = 2'd1,
        OWN_CPU_RD = 2'd2,
        OWN_CPU_WR = 2'd3
    } owner_t;

    // Bits needed to hold a count in 0..limit-1 (at least one bit).
    function automatic int cnt_width(input int limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction
endpackage

// File: rtl/vga_mem_arbiter_if.sv
// Bus bundle between the arbiter, the VGA reader, the CPU and the single-port RAM.
interface vga_mem_arbiter_if
    import vga_pkg::*;
#(
    parameter int AW = AW_DEF
);
    logic          vga_req;
    logic [AW-1:0] vga_addr;
    logic          vga_valid;
    logic [DW-1:0] vga_data;
    logic          vga_drop;

    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;

    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic [15:0]   drop_count;

    // Arbiter side.
    modport slave (
        input  vga_req, vga_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
        output vga_valid, vga_data, vga_drop, cpu_ack, cpu_rdata,
               mem_addr, mem_we, mem_wdata, drop_count
    );

    // Requester / RAM side.
    modport master (
        output vga_req, vga_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
        input  vga_valid, vga_data, vga_drop, cpu_ack, cpu_rdata,
               mem_addr, mem_we, mem_wdata, drop_count
    );
endinterface

// File: rtl/vga_starve_timer.sv
// Counts consecutive denied CPU request cycles and flags when the CPU must win.
module vga_starve_timer
    import vga_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic clk,
    input  logic clear,
    input  logic cpu_req,
    input  logic cpu_grant,
    output logic override
);
    localparam int            WW   = cnt_width(STARVE_LIMIT);
    localparam logic [WW-1:0] LAST = WW'(STARVE_LIMIT - 1);

    logic [WW-1:0] wait_cnt;

    // Wait counter: grows while the CPU is kept waiting, holds at the last value.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            wait_cnt <= '0;
        end else if (!cpu_req || cpu_grant) begin
            wait_cnt <= '0;
        end else if (wait_cnt != LAST) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign override = (wait_cnt == LAST);
endmodule

// File: rtl/vga_mem_arbiter.sv
// Single-port RAM arbiter: VGA reads win by default, a starved CPU wins over VGA.
//
// owner      | meaning
// -----------+-----------------------------------------------
// OWN_IDLE   | nothing granted last cycle, no data returning
// OWN_VGA_RD | VGA read granted last cycle, word returns now
// OWN_CPU_RD | CPU read granted last cycle, ack + read data
// OWN_CPU_WR | CPU write granted last cycle, ack only
module vga_mem_arbiter
    import vga_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int AW           = AW_DEF
) (
    input  logic              clk,
    input  logic              clear,
    vga_mem_arbiter_if.slave  bus
);
    owner_t        owner, owner_nxt;
    logic          cpu_busy, cpu_ok, override;
    logic          grant_vga, grant_cpu;
    logic [AW-1:0] addr_mux;
    logic          we_mux;
    logic [DW-1:0] wdata_mux;
    logic          drop_q;
    logic [15:0]   drop_cnt;

    vga_starve_timer #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve (
        .clk       (clk),
        .clear     (clear),
        .cpu_req   (bus.cpu_req),
        .cpu_grant (grant_cpu),
        .override  (override)
    );

    // A CPU access being acknowledged this cycle is never re-granted.
    assign cpu_busy = (owner == OWN_CPU_RD) || (owner == OWN_CPU_WR);

    // Arbitration, next owner and the RAM port mux.
    always_comb begin
        owner_nxt = OWN_IDLE;
        addr_mux  = '0;
        we_mux    = 1'b0;
        wdata_mux = '0;
        cpu_ok    = bus.cpu_req && !cpu_busy;
        grant_cpu = cpu_ok && (override || !bus.vga_req);
        grant_vga = bus.vga_req && !grant_cpu;
        if (grant_vga) begin
            owner_nxt = OWN_VGA_RD;
            addr_mux  = bus.vga_addr;
        end else if (grant_cpu) begin
            owner_nxt = bus.cpu_we ? OWN_CPU_WR : OWN_CPU_RD;
            addr_mux  = bus.cpu_addr;
            we_mux    = bus.cpu_we;
            wdata_mux = bus.cpu_wdata;
        end
        if (!clear) begin
            we_mux = 1'b0;
        end
    end

    // Owner register plus the drop pulse and its saturating counter.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            owner    <= OWN_IDLE;
            drop_q   <= 1'b0;
            drop_cnt <= '0;
        end else begin
            owner  <= owner_nxt;
            drop_q <= bus.vga_req && !grant_vga;
            if (bus.vga_req && !grant_vga && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

    assign bus.mem_addr   = addr_mux;
    assign bus.mem_we     = we_mux;
    assign bus.mem_wdata  = wdata_mux;
    assign bus.vga_valid  = (owner == OWN_VGA_RD);
    assign bus.vga_data   = (owner == OWN_VGA_RD) ? bus.mem_rdata : '0;
    assign bus.cpu_ack    = cpu_busy;
    assign bus.cpu_rdata  = (owner == OWN_CPU_RD) ? bus.mem_rdata : '0;
    assign bus.vga_drop   = drop_q;
    assign bus.drop_count = drop_cnt;
endmodule

// File: doc/vga_mem_arbiter.md
VGA_MEM_ARBITER -- requirements
Module: vga_mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 8, is the number of consecutive denied CPU request cycles after which the CPU wins over VGA.
REQ-002 Parameter AW, default 16, is the address width; data width is fixed at 16.
REQ-003 clk  in  1  single system clock; all state changes on the rising edge.
REQ-004 clear  in  1  reset, asynchronous, active-low.
REQ-005 vga_req  in  1  VGA address generator requests a glyph-word read this cycle.
REQ-006 vga_addr  in  AW  VGA read address.
REQ-007 vga_valid  out  1  vga_data valid, exactly one cycle after a VGA grant.
REQ-008 vga_data  out  16  read word returned to the VGA bit generator.
REQ-009 vga_drop  out  1  one-cycle pulse: the VGA request of the previous cycle was denied.
REQ-010 cpu_req  in  1  CPU memory request; held high with stable address/data until cpu_ack.
REQ-011 cpu_we  in  1  1 = write, 0 = read.
REQ-012 cpu_addr  in  AW  CPU address.
REQ-013 cpu_wdata  in  16  CPU write data.
REQ-014 cpu_ack  out  1  one-cycle completion pulse; cpu_rdata valid in this cycle for reads.
REQ-015 cpu_rdata  out  16  CPU read data.
REQ-016 mem_addr  out  AW  single-port RAM address (RAM registers it; 1-cycle read latency).
REQ-017 mem_we  out  1  RAM write enable.
REQ-018 mem_wdata  out  16  RAM write data.
REQ-019 mem_rdata  in  16  RAM read data, valid the cycle after the address is presented.
REQ-020 drop_count  out  16  saturating count of denied VGA requests since reset.

Function
REQ-021 Each cycle exactly one of {none, VGA, CPU} is granted; mem_addr/mem_we/mem_wdata are a combinational mux of the granted requester (none: addr 0, we 0).
REQ-022 Default priority: VGA over CPU.
REQ-023 CPU overrides VGA when wait_cnt == STARVE_LIMIT-1 and cpu_req is high.
REQ-024 wait_cnt increments each cycle cpu_req is high and not granted, clears on CPU grant or cpu_req low, and never exceeds STARVE_LIMIT-1.
REQ-025 The CPU is not granted in the cycle that cpu_ack is high, so the minimum spacing between CPU accesses is 2 cycles and a held request is never double-served.
REQ-026 State register owner ∈ {IDLE, VGA_RD, CPU_RD, CPU_WR} records the grant type for the data returning in the next cycle.
REQ-027 vga_valid = (owner==VGA_RD); vga_data = mem_rdata while valid, otherwise 0.
REQ-028 cpu_ack = (owner==CPU_RD or CPU_WR); cpu_rdata = mem_rdata when owner==CPU_RD, otherwise 0.
REQ-029 A write takes effect at the granting clock edge; a read at the same address granted in the next cycle returns the new data.
REQ-030 vga_drop is high in cycle N+1 iff vga_req was high and not granted in cycle N; drop_count increments on the same edge and saturates at 16'hFFFF.
REQ-031 Back-to-back VGA requests are granted every cycle, with vga_valid continuous, when no starvation override occurs.

Reset
REQ-032 While clear is low: owner=IDLE; wait_cnt=0; drop_count=0; vga_valid, vga_drop, and cpu_ack are 0; mem_we is forced 0 combinationally.
REQ-033 Reset asserted mid-access discards the in-flight access: no ack or valid is issued after release, and the CPU must re-request.
REQ-034 The first grant occurs on the first rising edge after clear is deasserted.

Structure
REQ-035 Shared package vga_pkg: owner state encoding, STARVE_LIMIT default, AW default.
REQ-036 One sub-module, vga_starve_timer, holds wait_cnt and the override flag; the rest is flat.

Verification
REQ-037 vga_req held high for 10 cycles, cpu idle: 10 consecutive vga_valid cycles; vga_data matches RAM at each addr+1 cycle later; vga_drop never asserts.
REQ-038 cpu write 16'hBEEF to 0x0040 then read 0x0040, no VGA traffic: ack at 1 cycle after each grant; read returns 16'hBEEF; accesses are ≥2 cycles apart.
REQ-039 vga_req and cpu_req both held continuously, STARVE_LIMIT=8: CPU granted on its 8th request cycle; one vga_drop pulse; drop_count=1.
REQ-040 Simultaneous vga_req and cpu_req for one cycle, then vga_req low: VGA is served first, CPU in the next cycle; no drop.
REQ-041 clear pulsed low during a CPU_RD cycle: no cpu_ack; all outputs 0; drop_count=0; normal operation resumes after release.
